cache_module: RTL and testbench
===============================

CACHE_MODULE -- requirements
Module: cache_module

Interface
REQ-001 Parameters, one per line: ADDR_W, default 32, address width; OFFSET_W, default 6, line-offset bits; INDEX_W, default 4, set-index bits (16 sets); WAYS, default 8, associativity (fixed at 8); TAG_W = ADDR_W-INDEX_W-OFFSET_W.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command strobe; accepted when cmd_valid and cmd_ready are both high.
REQ-005 cmd  in  4  0 L1 data read, 1 L1 data write, 2 L1 instruction read, 3 snoop invalidate, 4 snoop read, 5 snoop write, 6 snoop RFO, 8 clear, 9 print.
REQ-006 addr  in  ADDR_W  request address: tag=[ADDR_W-1:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W].
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 done  out  1  one-cycle pulse when a command completes.
REQ-009 hit  out  1  valid with done; tag matched a non-I line at lookup.
REQ-010 line_state  out  2  valid with done; final MESI state of the addressed line (I=0, S=1, E=2, M=3).
REQ-011 bus_op_valid / bus_op / bus_addr  out  1/3/ADDR_W  one-cycle bus request; bus_op: READ=1, WRITE=2, INVALIDATE=3, RWIM=4; bus_addr is line-aligned (offset bits zero).
REQ-012 snoop_in  in  2  other caches' snoop result (NOHIT=0, HIT=1, HITM=2); sampled in the cycle bus_op_valid is high with READ.
REQ-013 put_snoop_valid / put_snoop  out  1/2  this cache's snoop response to cmd 4, 5 and 6; pulsed together with done.
REQ-014 read_cnt, write_cnt, hit_cnt, evict_cnt  out  32 each  statistics counters.
REQ-015 err  out  1  pulsed with done for an unsupported cmd (7, 10-15).

Function
REQ-016 FSM states: IDLE, LOOKUP, WRBACK, BUSREQ, UPDATE, CLEAR; an accepted command moves to LOOKUP.
REQ-017 LOOKUP compares the tag against all 8 ways of the set; hit is a match on a way whose state is not I.
REQ-018 L1 read miss (cmd 0/2): issue READ; snoop_in HIT or HITM -> E? no: HIT or HITM -> S; NOHIT -> E.
REQ-019 L1 read hit: no bus op, state unchanged.
REQ-020 L1 write miss: issue RWIM; line -> M.
REQ-021 L1 write hit: M and E -> M with no bus op; S -> issue INVALIDATE, then -> M.
REQ-022 Miss fill uses the lowest-numbered I way; if there is none, the PLRU victim is used and evict_cnt increments.
REQ-023 If the victim is M, a WRITE bus op to {victim_tag,index,0} precedes the fill bus op in WRBACK.
REQ-024 Snoop read (cmd 4): M -> put HITM, issue WRITE, -> S; E -> put HIT, -> S; S -> put HIT; miss -> put NOHIT.
REQ-025 Snoop RFO (cmd 6): M -> put HITM, issue WRITE, -> I; E or S -> put HIT, -> I; miss -> put NOHIT.
REQ-026 Snoop write (cmd 5): put NOHIT, no state change.
REQ-027 Snoop invalidate (cmd 3): S -> I; all other states unchanged; no put_snoop.
REQ-028 Pseudo-LRU is a 7-bit binary tree per set, updated on every L1 hit and fill and never on snoops; the victim follows the tree bits away from recent use.
REQ-029 Counters: read_cnt += cmd 0/2; write_cnt += cmd 1; hit_cnt += L1 hits only; snoops do not count. All counters wrap at 2^32.
REQ-030 Latency: done occurs 2 cycles after acceptance, plus 1 cycle per bus op issued; at most 2 bus ops per command.
REQ-031 Clear (cmd 8): CLEAR sweeps one set per cycle, setting all lines to I and PLRU to 0; all four counters zero; done after 16 sweep cycles.
REQ-032 Print (cmd 9): no state change; done in 2 cycles.
REQ-033 Unsupported command: no state change; done with err in 2 cycles.

Reset
REQ-034 rst forces state IDLE, all lines I, PLRU 0, all counters 0, and all pulse and data outputs 0; cmd_ready is 1 after release.
REQ-035 rst asserted mid-command aborts the command with no done and no further bus op.

Structure
REQ-036 A shared package cache_pkg holds the command, MESI, bus-op and snoop-result encodings and the default widths.
REQ-037 One sub-module cache_plru holds the per-set tree update and victim select; the MESI next-state logic is a function in cache_pkg.

Verification
REQ-038 Read 0x1000_0000 with snoop_in=NOHIT -> bus READ 0x1000_0000, hit=0, line_state=E; repeat -> hit=1, no bus op, hit_cnt=1.
REQ-039 Write 0x1000_0000 (E) -> no bus op, M; then snoop read 0x1000_0000 -> put_snoop=HITM, bus WRITE 0x1000_0000, state S.
REQ-040 Read 0x2000_0040 with snoop_in=HIT -> S; write it -> bus INVALIDATE 0x2000_0040, state M.
REQ-041 Write 9 tags to index 0 (0x0000_0000 + n*0x400, n=0..8) -> 9th: evict_cnt=1, bus WRITE 0x0000_0000 (way 0 victim, M), then RWIM 0x0000_2000.
REQ-042 Clear after REQ-038 -> all counters 0, and re-reading 0x1000_0000 misses.
REQ-043 Assert rst during the WRBACK of REQ-041 -> no done, cmd_ready=1, counters 0, and the next read misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared encodings and MESI/snoop-response rules for the 8-way set-associative cache.
package cache_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int OFFSET_W_DEF = 6;
  localparam int INDEX_W_DEF  = 4;
  localparam int WAYS_DEF     = 8;
  localparam int PLRU_W       = 7;

  localparam logic [3:0] CMD_RD    = 4'd0;
  localparam logic [3:0] CMD_WR    = 4'd1;
  localparam logic [3:0] CMD_IRD   = 4'd2;
  localparam logic [3:0] CMD_SINV  = 4'd3;
  localparam logic [3:0] CMD_SRD   = 4'd4;
  localparam logic [3:0] CMD_SWR   = 4'd5;
  localparam logic [3:0] CMD_SRFO  = 4'd6;
  localparam logic [3:0] CMD_CLR   = 4'd8;
  localparam logic [3:0] CMD_PRINT = 4'd9;

  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2, BUS_INV = 3'd3, BUS_RWIM = 3'd4
  } bus_op_e;

  typedef enum logic [1:0] {SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2} snoop_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WRBACK, ST_BUSREQ, ST_UPDATE, ST_CLEAR
  } state_e;

  // Final state of the addressed line; cur is I whenever the lookup missed.
  function automatic mesi_e mesi_next(input logic [3:0] c, input logic hit,
                                      input mesi_e cur, input logic [1:0] snp);
    mesi_e n;
    n = hit ? cur : MESI_I;
    case (c)
      CMD_RD, CMD_IRD: if (!hit) n = (snp == SNP_HIT || snp == SNP_HITM) ? MESI_S : MESI_E;
      CMD_WR:          n = MESI_M;
      CMD_SINV:        if (cur == MESI_S) n = MESI_I;
      CMD_SRD:         if (hit) n = MESI_S;
      CMD_SRFO:        n = MESI_I;
      CMD_SWR, CMD_PRINT: ;
      default:         n = MESI_I;
    endcase
    return n;
  endfunction

  function automatic snoop_e snoop_resp(input logic [3:0] c, input logic hit, input mesi_e cur);
    if (!hit || c == CMD_SWR) return SNP_NOHIT;
    if (cur == MESI_M) return SNP_HITM;
    return SNP_HIT;
  endfunction

endpackage

// File: rtl/cache_plru.sv
// 7-bit tree pseudo-LRU for one 8-way set: node bit 0 points left, 1 points right.
module cache_plru
  import cache_pkg::*;
(
  input  logic [PLRU_W-1:0] i_tree,
  input  logic [2:0]        i_access_way,
  output logic [PLRU_W-1:0] o_tree_next,
  output logic [2:0]        o_victim_way
);

  logic [2:0] w_mid_node;
  logic [2:0] w_leaf_node;
  logic [1:0] w_upper;

  assign w_mid_node  = {2'b00, i_access_way[2]} + 3'd1;
  assign w_leaf_node = {1'b0, i_access_way[2:1]} + 3'd3;

  // Every node on the accessed path is turned to point at the other half.
  always_comb begin
    o_tree_next              = i_tree;
    o_tree_next[0]           = ~i_access_way[2];
    o_tree_next[w_mid_node]  = ~i_access_way[1];
    o_tree_next[w_leaf_node] = ~i_access_way[0];
  end

  assign w_upper[1]   = i_tree[0];
  assign w_upper[0]   = i_tree[0] ? i_tree[2] : i_tree[1];
  assign o_victim_way = {w_upper, i_tree[{1'b0, w_upper} + 3'd3]};

endmodule

// File: rtl/cache_module.sv
// MESI L2 cache controller: 16 sets x 8 ways, PLRU replacement, one command at a time.
module cache_module
  import cache_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int WAYS     = WAYS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  output logic              cmd_ready,
  output logic              done,
  output logic              hit,
  output logic [1:0]        line_state,
  output logic              bus_op_valid,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        snoop_in,
  output logic              put_snoop_valid,
  output logic [1:0]        put_snoop,
  output logic [31:0]       read_cnt,
  output logic [31:0]       write_cnt,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       evict_cnt,
  output logic              err
);

  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  state_e               r_state, w_state_next;
  logic [3:0]           r_cmd;
  logic [LINE_W-1:0]    r_line;
  logic [TAG_W-1:0]     r_tags [SETS][WAYS];
  mesi_e                r_mesi [SETS][WAYS];
  logic [PLRU_W-1:0]    r_plru [SETS];
  logic                 r_hit, r_evict;
  logic [2:0]           r_way;
  mesi_e                r_cur;
  logic [TAG_W-1:0]     r_wb_tag;
  bus_op_e              r_bus_op;
  logic [1:0]           r_snoop;
  logic [INDEX_W-1:0]   r_clr_idx;
  logic [31:0]          r_read_cnt, r_write_cnt, r_hit_cnt, r_evict_cnt;

  logic [INDEX_W-1:0]   w_index;
  logic [TAG_W-1:0]     w_tag;
  logic [WAYS-1:0]      w_match, w_free;
  logic [2:0]           w_hit_way, w_free_way, w_victim_way, w_fill_way, w_way;
  logic                 w_hit, w_has_free, w_need_wb;
  logic                 w_is_rd, w_is_wr, w_is_l1, w_is_snp, w_is_resp, w_unsup, w_lookup_cmd;
  mesi_e                w_cur, w_new_state;
  bus_op_e              w_bus_op;
  logic [PLRU_W-1:0]    w_plru_next;

  assign w_index = r_line[INDEX_W-1:0];
  assign w_tag   = r_line[LINE_W-1:INDEX_W];

  assign w_is_rd      = (r_cmd == CMD_RD) || (r_cmd == CMD_IRD);
  assign w_is_wr      = (r_cmd == CMD_WR);
  assign w_is_l1      = w_is_rd || w_is_wr;
  assign w_is_snp     = (r_cmd >= CMD_SINV) && (r_cmd <= CMD_SRFO);
  assign w_is_resp    = (r_cmd >= CMD_SRD) && (r_cmd <= CMD_SRFO);
  assign w_unsup      = (r_cmd == 4'd7) || (r_cmd >= 4'd10);
  assign w_lookup_cmd = !w_unsup && (r_cmd != CMD_CLR);

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign w_match[gi] = (r_mesi[w_index][gi] != MESI_I) && (r_tags[w_index][gi] == w_tag);
      assign w_free[gi]  = (r_mesi[w_index][gi] == MESI_I);
    end
  endgenerate

  always_comb begin
    w_hit_way  = '0;
    w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_match[i]) w_hit_way = 3'(i);
      if (w_free[i])  w_free_way = 3'(i);
    end
  end

  assign w_hit      = |w_match;
  assign w_has_free = |w_free;
  assign w_fill_way = w_has_free ? w_free_way : w_victim_way;
  assign w_way      = w_hit ? w_hit_way : w_fill_way;
  assign w_cur      = w_hit ? r_mesi[w_index][w_hit_way] : MESI_I;
  assign w_need_wb  = w_is_l1 && !w_hit && !w_has_free && (r_mesi[w_index][w_victim_way] == MESI_M);
  assign w_new_state = mesi_next(r_cmd, r_hit, r_cur, r_snoop);

  cache_plru u_plru (
    .i_tree       (r_plru[w_index]),
    .i_access_way (r_way),
    .o_tree_next  (w_plru_next),
    .o_victim_way (w_victim_way)
  );

  always_comb begin
    w_bus_op = BUS_NONE;
    if (w_is_l1 && !w_hit)                                        w_bus_op = w_is_wr ? BUS_RWIM : BUS_READ;
    else if (w_is_wr && w_cur == MESI_S)                          w_bus_op = BUS_INV;
    else if ((r_cmd == CMD_SRD || r_cmd == CMD_SRFO) && w_cur == MESI_M) w_bus_op = BUS_WRITE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid) w_state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (r_cmd == CMD_CLR)          w_state_next = ST_CLEAR;
        else if (w_need_wb)            w_state_next = ST_WRBACK;
        else if (w_bus_op != BUS_NONE) w_state_next = ST_BUSREQ;
        else                           w_state_next = ST_UPDATE;
      end
      ST_WRBACK: w_state_next = ST_BUSREQ;
      ST_BUSREQ: w_state_next = ST_UPDATE;
      ST_CLEAR:  if (r_clr_idx == INDEX_W'(SETS - 1)) w_state_next = ST_UPDATE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (r_state == ST_IDLE);
    done            = (r_state == ST_UPDATE);
    hit             = done && r_hit;
    line_state      = done ? w_new_state : MESI_I;
    err             = done && w_unsup;
    put_snoop_valid = done && w_is_resp;
    put_snoop       = put_snoop_valid ? snoop_resp(r_cmd, r_hit, r_cur) : SNP_NOHIT;
    bus_op_valid    = (r_state == ST_WRBACK) || (r_state == ST_BUSREQ);
    bus_op          = BUS_NONE;
    bus_addr        = '0;
    if (r_state == ST_WRBACK) begin
      bus_op   = BUS_WRITE;
      bus_addr = {r_wb_tag, w_index, {OFFSET_W{1'b0}}};
    end else if (r_state == ST_BUSREQ) begin
      bus_op   = r_bus_op;
      bus_addr = {r_line, {OFFSET_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd       <= '0;
      r_line      <= '0;
      r_hit       <= 1'b0;
      r_evict     <= 1'b0;
      r_way       <= '0;
      r_cur       <= MESI_I;
      r_wb_tag    <= '0;
      r_bus_op    <= BUS_NONE;
      r_snoop     <= SNP_NOHIT;
      r_clr_idx   <= '0;
      r_read_cnt  <= '0;
      r_write_cnt <= '0;
      r_hit_cnt   <= '0;
      r_evict_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_mesi[s][w] <= MESI_I;
      end
    end else begin
      case (r_state)
        ST_IDLE: if (cmd_valid) begin
          r_cmd  <= cmd;
          r_line <= addr[ADDR_W-1:OFFSET_W];
        end
        ST_LOOKUP: begin
          r_hit     <= w_hit && w_lookup_cmd;
          r_way     <= w_way;
          r_cur     <= w_cur;
          r_wb_tag  <= r_tags[w_index][w_fill_way];
          r_bus_op  <= w_bus_op;
          r_evict   <= w_is_l1 && !w_hit && !w_has_free;
          r_snoop   <= SNP_NOHIT;
          r_clr_idx <= '0;
        end
        ST_BUSREQ: if (r_bus_op == BUS_READ) r_snoop <= snoop_in;
        ST_CLEAR: begin
          for (int w = 0; w < WAYS; w++) r_mesi[r_clr_idx][w] <= MESI_I;
          r_plru[r_clr_idx] <= '0;
          r_clr_idx         <= r_clr_idx + 1'b1;
        end
        ST_UPDATE: begin
          // Snoops may change MESI state but never touch the replacement tree.
          if (w_is_l1) begin
            r_mesi[w_index][r_way] <= w_new_state;
            r_plru[w_index]        <= w_plru_next;
          end else if (w_is_snp && r_hit) begin
            r_mesi[w_index][r_way] <= w_new_state;
          end
          if (r_cmd == CMD_CLR) begin
            r_read_cnt  <= '0;
            r_write_cnt <= '0;
            r_hit_cnt   <= '0;
            r_evict_cnt <= '0;
          end else begin
            r_read_cnt  <= r_read_cnt + 32'(w_is_rd);
            r_write_cnt <= r_write_cnt + 32'(w_is_wr);
            r_hit_cnt   <= r_hit_cnt + 32'(w_is_l1 && r_hit);
            r_evict_cnt <= r_evict_cnt + 32'(r_evict);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_UPDATE && w_is_l1 && !r_hit) r_tags[w_index][r_way] <= w_tag;
  end

  assign read_cnt  = r_read_cnt;
  assign write_cnt = r_write_cnt;
  assign hit_cnt   = r_hit_cnt;
  assign evict_cnt = r_evict_cnt;

endmodule

// File: tb/tb_cache_module.sv
// Randomised and directed bench for cache_module against an array-based MESI/PLRU reference model.
module tb_cache_module;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd = '0;
  logic [31:0] addr = '0;
  logic [1:0]  snoop_in = '0;
  logic        cmd_ready, done, hit, bus_op_valid, put_snoop_valid, err;
  logic [1:0]  line_state, put_snoop;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr, read_cnt, write_cnt, hit_cnt, evict_cnt;

  always #5 clk = ~clk;

  cache_module dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
    .cmd_ready(cmd_ready), .done(done), .hit(hit), .line_state(line_state),
    .bus_op_valid(bus_op_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .snoop_in(snoop_in), .put_snoop_valid(put_snoop_valid), .put_snoop(put_snoop),
    .read_cnt(read_cnt), .write_cnt(write_cnt), .hit_cnt(hit_cnt),
    .evict_cnt(evict_cnt), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays, states I=0 S=1 E=2 M=3, tree kept as a heap of node bits.
  logic [21:0] m_tag  [16][8];
  int          m_st   [16][8];
  int          m_tree [16][7];
  int unsigned m_rd, m_wr, m_hc, m_ev;

  int          e_hit, e_state, e_err, e_psv, e_ps, e_lat;
  logic [34:0] e_ops [$];
  int          last_hit;

  function automatic void m_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 8; w++) m_st[s][w] = 0;
      for (int n = 0; n < 7; n++) m_tree[s][n] = 0;
    end
    m_rd = 0; m_wr = 0; m_hc = 0; m_ev = 0;
  endfunction

  function automatic int m_victim(input int s);
    int n = 0;
    for (int l = 0; l < 3; l++) n = 2 * n + 1 + m_tree[s][n];
    return n - 7;
  endfunction

  function automatic void m_touch(input int s, input int w);
    int n = w + 7;
    int p;
    while (n > 0) begin
      p = (n - 1) / 2;
      m_tree[s][p] = (n % 2 == 1) ? 1 : 0;
      n = p;
    end
  endfunction

  function automatic void m_apply(input int c, input logic [31:0] a, input int snp);
    int s = int'(a[9:6]);
    logic [21:0] t = a[31:10];
    logic [31:0] line = {a[31:6], 6'd0};
    int hw = -1;
    int fw;
    for (int w = 0; w < 8; w++) if (m_st[s][w] != 0 && m_tag[s][w] == t) hw = w;
    e_ops.delete();
    e_err = 0; e_psv = 0; e_ps = 0;
    e_hit = (hw >= 0);
    e_state = (hw >= 0) ? m_st[s][hw] : 0;
    case (c)
      0, 1, 2: begin
        if (c == 1) m_wr++; else m_rd++;
        if (hw >= 0) begin
          m_hc++;
          if (c == 1) begin
            if (m_st[s][hw] == 1) e_ops.push_back({3'd3, line});
            m_st[s][hw] = 3;
          end
        end else begin
          fw = -1;
          for (int w = 7; w >= 0; w--) if (m_st[s][w] == 0) fw = w;
          if (fw < 0) begin
            fw = m_victim(s);
            m_ev++;
            if (m_st[s][fw] == 3) e_ops.push_back({3'd2, m_tag[s][fw], 4'(s), 6'd0});
          end
          e_ops.push_back({(c == 1) ? 3'd4 : 3'd1, line});
          m_tag[s][fw] = t;
          m_st[s][fw]  = (c == 1) ? 3 : ((snp == 1 || snp == 2) ? 1 : 2);
          hw = fw;
        end
        m_touch(s, hw);
        e_state = m_st[s][hw];
      end
      3: if (hw >= 0 && m_st[s][hw] == 1) begin m_st[s][hw] = 0; e_state = 0; end
      4: begin
        e_psv = 1;
        if (hw >= 0) begin
          e_ps = (m_st[s][hw] == 3) ? 2 : 1;
          if (m_st[s][hw] == 3) e_ops.push_back({3'd2, line});
          m_st[s][hw] = 1;
          e_state = 1;
        end
      end
      5: e_psv = 1;
      6: begin
        e_psv = 1;
        if (hw >= 0) begin
          e_ps = (m_st[s][hw] == 3) ? 2 : 1;
          if (m_st[s][hw] == 3) e_ops.push_back({3'd2, line});
          m_st[s][hw] = 0;
        end
        e_state = 0;
      end
      8: begin m_reset(); e_hit = 0; e_state = 0; end
      9: ;
      default: begin e_err = 1; e_hit = 0; e_state = 0; end
    endcase
    e_lat = (c == 8) ? 18 : 2 + e_ops.size();
  endfunction

  task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] snp);
    logic [34:0] got_ops [$];
    int   lat = 0;
    bit   seen = 0;
    logic g_hit = 0, g_err = 0, g_psv = 0;
    logic [1:0] g_st = 0, g_ps = 0;
    m_apply(int'(c), a, int'(snp));
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd = c; addr = a; snoop_in = snp;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (bus_op_valid) got_ops.push_back({bus_op, bus_addr});
      if (done) begin
        seen = 1; lat = cyc;
        g_hit = hit; g_st = line_state; g_err = err; g_psv = put_snoop_valid; g_ps = put_snoop;
      end
    end
    chk("done_seen", seen, 1);
    chk("latency", lat, e_lat);
    chk("hit", g_hit, e_hit);
    chk("line_state", g_st, e_state);
    chk("err", g_err, e_err);
    chk("put_snoop_valid", g_psv, e_psv);
    chk("put_snoop", g_ps, e_ps);
    chk("bus_op_count", got_ops.size(), e_ops.size());
    for (int i = 0; i < got_ops.size() && i < e_ops.size(); i++) chk("bus_op", got_ops[i], e_ops[i]);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("read_cnt", read_cnt, m_rd);
    chk("write_cnt", write_cnt, m_wr);
    chk("hit_cnt", hit_cnt, m_hc);
    chk("evict_cnt", evict_cnt, m_ev);
    last_hit = int'(g_hit);
    $display("TXN cmd=%0d addr=%08h snp=%0d hit=%0d state=%0d ops=%0d lat=%0d",
             c, a, snp, g_hit, g_st, got_ops.size(), lat);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int r;
    logic [3:0]  rc;
    logic [31:0] ra;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busop", bus_op_valid, 0);
    chk("rst_busaddr", bus_addr, 0);
    chk("rst_psv", put_snoop_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_counts", {read_cnt, write_cnt} | {hit_cnt, evict_cnt}, 0);

    // Read miss then hit
    run_cmd(4'd0, 32'h1000_0000, 2'd0);
    chk("req038_miss", last_hit, 0);
    run_cmd(4'd0, 32'h1000_0000, 2'd0);
    chk("req038_hit", last_hit, 1);
    chk("req038_hitcnt", hit_cnt, 1);
    // Clear then re-read misses
    run_cmd(4'd8, 32'h0, 2'd0);
    chk("req042_cnt", read_cnt, 0);
    run_cmd(4'd0, 32'h1000_0000, 2'd0);
    chk("req042_miss", last_hit, 0);
    // E write, snoop read of M
    run_cmd(4'd1, 32'h1000_0000, 2'd0);
    run_cmd(4'd4, 32'h1000_0000, 2'd0);
    // Shared read then write-upgrade
    run_cmd(4'd0, 32'h2000_0040, 2'd1);
    run_cmd(4'd1, 32'h2000_0040, 2'd0);
    // Fill index 0 and evict
    run_cmd(4'd8, 32'h0, 2'd0);
    for (int n = 0; n < 9; n++) run_cmd(4'd1, 32'(n * 32'h400), 2'd0);
    chk("req041_evict", evict_cnt, 1);

    // Reset during write-back
    run_cmd(4'd8, 32'h0, 2'd0);
    for (int n = 0; n < 8; n++) run_cmd(4'd1, 32'(n * 32'h400), 2'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = 4'd1; addr = 32'h0000_2000; snoop_in = 2'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      if (bus_op_valid && bus_op == 3'd2) found = 1;
    end
    chk("req043_wrback_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("req043_ready", cmd_ready, 1);
    chk("req043_busop", bus_op_valid, 0);
    chk("req043_counts", {read_cnt, write_cnt} | {hit_cnt, evict_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      chk("req043_quiet_bus", bus_op_valid, 0);
      chk("req043_quiet_done", done, 0);
    end
    run_cmd(4'd0, 32'h0000_0000, 2'd0);
    chk("req043_miss", last_hit, 0);

    // Random traffic over a small footprint so hits, conflicts and evictions are common
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r < 15)       rc = 4'(r % 7);
      else if (r == 15) rc = 4'd9;
      else if (r == 16) rc = 4'd7;
      else if (r == 17) rc = 4'($urandom_range(10, 15));
      else if (r == 18) rc = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'd1;
      else              rc = 4'd0;
      ra = (32'($urandom_range(0, 11)) << 10) | (32'($urandom_range(0, 1)) << 6)
         | 32'($urandom_range(0, 63));
      run_cmd(rc, ra, 2'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
